// File: rtl/branch_rs_pkg.sv
// Shared widths, opcode encodings, entry layout and the CDB snoop helper
// for the branch reservation station.
package branch_rs_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [OP_W-1:0]   op_bus_t;
    typedef logic [TAG_W-1:0]  tag_bus_t;
    typedef logic [DATA_W-1:0] data_bus_t;
    typedef logic [ADDR_W-1:0] addr_bus_t;

    typedef enum logic [OP_W-1:0] {
        OP_NULL = 6'd0,
        OP_JAL  = 6'd1,
        OP_JALR = 6'd2,
        OP_BEQ  = 6'd3,
        OP_BNE  = 6'd4,
        OP_BLT  = 6'd5,
        OP_BGE  = 6'd6,
        OP_BLTU = 6'd7,
        OP_BGEU = 6'd8
    } br_op_e;

    localparam logic      ENABLE    = 1'b1;
    localparam logic      DISABLE   = 1'b0;
    localparam logic      SUC       = 1'b1;
    localparam logic      FAIL      = 1'b0;
    localparam data_bus_t NULL_DATA = '0;
    localparam tag_bus_t  NULL_TAG  = '0;

    typedef struct packed {
        logic      valid;
        op_bus_t   op;
        data_bus_t v1;
        tag_bus_t  q1;
        logic      r1;
        data_bus_t v2;
        tag_bus_t  q2;
        logic      r2;
        tag_bus_t  des;
        data_bus_t imm;
        addr_bus_t pc;
        logic      bp;
    } rs_entry_t;

    typedef struct packed {
        logic      hit;
        data_bus_t data;
    } snoop_t;

    // Looks up a producer tag on both broadcast buses; cdb0 wins a tie.
    function automatic snoop_t cdb_snoop(
        input tag_bus_t  q,
        input logic      en0,
        input tag_bus_t  tag0,
        input data_bus_t data0,
        input logic      en1,
        input tag_bus_t  tag1,
        input data_bus_t data1
    );
        snoop_t s;
        s.hit  = FAIL;
        s.data = NULL_DATA;
        if (en0 && tag0 == q) begin
            s.hit  = SUC;
            s.data = data0;
        end else if (en1 && tag1 == q) begin
            s.hit  = SUC;
            s.data = data1;
        end
        return s;
    endfunction

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, CDB snoop and branch-unit issue signals of the branch RS.
interface branch_rs_if import branch_rs_pkg::*; ();

    logic      disp_en_i;
    op_bus_t   disp_op_i;
    data_bus_t disp_v1_i;
    tag_bus_t  disp_q1_i;
    logic      disp_r1_i;
    data_bus_t disp_v2_i;
    tag_bus_t  disp_q2_i;
    logic      disp_r2_i;
    tag_bus_t  disp_des_i;
    data_bus_t disp_imm_i;
    addr_bus_t disp_pc_i;
    logic      disp_bp_i;

    logic      cdb0_en_i;
    tag_bus_t  cdb0_tag_i;
    data_bus_t cdb0_data_i;
    logic      cdb1_en_i;
    tag_bus_t  cdb1_tag_i;
    data_bus_t cdb1_data_i;

    logic      rs_full_o;
    logic      br_en_o;
    op_bus_t   br_op_o;
    data_bus_t br_reg1_o;
    data_bus_t br_reg2_o;
    tag_bus_t  br_des_o;
    data_bus_t br_imm_o;
    addr_bus_t br_pc_o;
    logic      br_bp_o;

    modport master (
        output disp_en_i, disp_op_i, disp_v1_i, disp_q1_i, disp_r1_i,
               disp_v2_i, disp_q2_i, disp_r2_i, disp_des_i, disp_imm_i,
               disp_pc_i, disp_bp_i,
               cdb0_en_i, cdb0_tag_i, cdb0_data_i,
               cdb1_en_i, cdb1_tag_i, cdb1_data_i,
        input  rs_full_o, br_en_o, br_op_o, br_reg1_o, br_reg2_o,
               br_des_o, br_imm_o, br_pc_o, br_bp_o
    );

    modport slave (
        input  disp_en_i, disp_op_i, disp_v1_i, disp_q1_i, disp_r1_i,
               disp_v2_i, disp_q2_i, disp_r2_i, disp_des_i, disp_imm_i,
               disp_pc_i, disp_bp_i,
               cdb0_en_i, cdb0_tag_i, cdb0_data_i,
               cdb1_en_i, cdb1_tag_i, cdb1_data_i,
        output rs_full_o, br_en_o, br_op_o, br_reg1_o, br_reg2_o,
               br_des_o, br_imm_o, br_pc_o, br_bp_o
    );

endinterface

// File: rtl/branch_rs_sel.sv
// Lowest-index priority encoder: flags whether any request bit is set and
// returns the index of the lowest one.
module branch_rs_sel #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [RS_SIZE-1:0] req,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan upward and keep only the first set bit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: holds dispatched JAL/JALR/Bxx ops, wakes
// operands from two CDBs and issues one ready entry per cycle into a
// registered interface to the combinational branch unit.
module branch_rs import branch_rs_pkg::*; #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_i,
    branch_rs_if.slave  bus
);

    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          new_ent;
    snoop_t             wk1 [RS_SIZE];
    snoop_t             wk2 [RS_SIZE];
    snoop_t             byp1;
    snoop_t             byp2;
    logic [RS_SIZE-1:0] valid_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               rdy_found;
    logic [IDX_W-1:0]   rdy_idx;

    logic               br_en_q;
    op_bus_t            br_op_q;
    data_bus_t          br_reg1_q;
    data_bus_t          br_reg2_q;
    tag_bus_t           br_des_q;
    data_bus_t          br_imm_q;
    addr_bus_t          br_pc_q;
    logic               br_bp_q;

    // Per-entry CDB matches and registered valid/ready vectors.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            wk1[i] = cdb_snoop(ent_q[i].q1, bus.cdb0_en_i, bus.cdb0_tag_i, bus.cdb0_data_i,
                               bus.cdb1_en_i, bus.cdb1_tag_i, bus.cdb1_data_i);
            wk2[i] = cdb_snoop(ent_q[i].q2, bus.cdb0_en_i, bus.cdb0_tag_i, bus.cdb0_data_i,
                               bus.cdb1_en_i, bus.cdb1_tag_i, bus.cdb1_data_i);
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid & ent_q[i].r1 & ent_q[i].r2;
        end
    end

    // Incoming entry with same-cycle CDB bypass applied to pending operands.
    always_comb begin
        byp1 = cdb_snoop(bus.disp_q1_i, bus.cdb0_en_i, bus.cdb0_tag_i, bus.cdb0_data_i,
                         bus.cdb1_en_i, bus.cdb1_tag_i, bus.cdb1_data_i);
        byp2 = cdb_snoop(bus.disp_q2_i, bus.cdb0_en_i, bus.cdb0_tag_i, bus.cdb0_data_i,
                         bus.cdb1_en_i, bus.cdb1_tag_i, bus.cdb1_data_i);
        new_ent       = '0;
        new_ent.valid = ENABLE;
        new_ent.op    = bus.disp_op_i;
        new_ent.q1    = bus.disp_q1_i;
        new_ent.q2    = bus.disp_q2_i;
        new_ent.des   = bus.disp_des_i;
        new_ent.imm   = bus.disp_imm_i;
        new_ent.pc    = bus.disp_pc_i;
        new_ent.bp    = bus.disp_bp_i;
        new_ent.r1    = bus.disp_r1_i | byp1.hit;
        new_ent.v1    = (!bus.disp_r1_i && byp1.hit) ? byp1.data : bus.disp_v1_i;
        new_ent.r2    = bus.disp_r2_i | byp2.hit;
        new_ent.v2    = (!bus.disp_r2_i && byp2.hit) ? byp2.data : bus.disp_v2_i;
    end

    branch_rs_sel #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .req   (~valid_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    branch_rs_sel #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .found (rdy_found),
        .idx   (rdy_idx)
    );

    // Entry storage, wakeup, issue register and dispatch write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            br_en_q   <= DISABLE;
            br_op_q   <= '0;
            br_reg1_q <= '0;
            br_reg2_q <= '0;
            br_des_q  <= '0;
            br_imm_q  <= '0;
            br_pc_q   <= '0;
            br_bp_q   <= 1'b0;
        end else if (clear_i) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i].valid <= DISABLE;
            end
            br_en_q <= DISABLE;
        end else if (!rdy_in) begin
            br_en_q <= DISABLE;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].valid && !ent_q[i].r1 && wk1[i].hit) begin
                    ent_q[i].r1 <= ENABLE;
                    ent_q[i].v1 <= wk1[i].data;
                end
                if (ent_q[i].valid && !ent_q[i].r2 && wk2[i].hit) begin
                    ent_q[i].r2 <= ENABLE;
                    ent_q[i].v2 <= wk2[i].data;
                end
            end
            // Select works on registered ready bits, so a wakeup at this edge
            // only becomes issuable at the next one.
            if (rdy_found) begin
                ent_q[rdy_idx].valid <= DISABLE;
                br_en_q   <= ENABLE;
                br_op_q   <= ent_q[rdy_idx].op;
                br_reg1_q <= ent_q[rdy_idx].v1;
                br_reg2_q <= ent_q[rdy_idx].v2;
                br_des_q  <= ent_q[rdy_idx].des;
                br_imm_q  <= ent_q[rdy_idx].imm;
                br_pc_q   <= ent_q[rdy_idx].pc;
                br_bp_q   <= ent_q[rdy_idx].bp;
            end else begin
                br_en_q <= DISABLE;
            end
            if (bus.disp_en_i && free_found) begin
                ent_q[free_idx] <= new_ent;
            end
        end
    end

    assign bus.rs_full_o = &valid_vec;
    assign bus.br_en_o   = br_en_q;
    assign bus.br_op_o   = br_op_q;
    assign bus.br_reg1_o = br_reg1_q;
    assign bus.br_reg2_o = br_reg2_q;
    assign bus.br_des_o  = br_des_q;
    assign bus.br_imm_o  = br_imm_q;
    assign bus.br_pc_o   = br_pc_q;
    assign bus.br_bp_o   = br_bp_q;

    a_no_disp_when_full: assert property (
        @(posedge clk_in) disable iff (!rst_n_in)
        (rdy_in && !clear_i && bus.disp_en_i) |-> !bus.rs_full_o
    );

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs with a slot-level behavioural model and
// per-cycle comparison of every output.
module tb_branch_rs;
    import branch_rs_pkg::*;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b1;
    logic clear_i  = 1'b0;

    branch_rs_if bus ();

    branch_rs #(.RS_SIZE(8), .IDX_W(3)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .clear_i  (clear_i),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        valid;
        bit [5:0]  op;
        bit [31:0] v1, v2, imm, pc;
        bit [3:0]  q1, q2, des;
        bit        r1, r2, bp;
    } m_ent_t;

    m_ent_t    m [8];
    logic      e_en;
    logic [5:0]  e_op;
    logic [31:0] e_r1, e_r2, e_imm, e_pc;
    logic [3:0]  e_des;
    logic        e_bp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '{default: 0};
        e_en = 0; e_op = 0; e_r1 = 0; e_r2 = 0; e_imm = 0; e_pc = 0; e_des = 0; e_bp = 0;
    endtask

    task automatic lookup(input bit [3:0] q, output bit hit, output bit [31:0] d);
        hit = 0; d = 0;
        if (bus.cdb0_en_i && bus.cdb0_tag_i == q) begin hit = 1; d = bus.cdb0_data_i; end
        else if (bus.cdb1_en_i && bus.cdb1_tag_i == q) begin hit = 1; d = bus.cdb1_data_i; end
    endtask

    task automatic model_step();
        m_ent_t s [8];
        int pick = -1;
        int slot = -1;
        bit hit;
        bit [31:0] d;
        s = m;
        if (clear_i) begin
            for (int i = 0; i < 8; i++) m[i].valid = 0;
            e_en = 0;
            return;
        end
        if (!rdy_in) begin
            e_en = 0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (s[i].valid && !s[i].r1) begin
                lookup(s[i].q1, hit, d);
                if (hit) begin m[i].r1 = 1; m[i].v1 = d; end
            end
            if (s[i].valid && !s[i].r2) begin
                lookup(s[i].q2, hit, d);
                if (hit) begin m[i].r2 = 1; m[i].v2 = d; end
            end
            if (pick < 0 && s[i].valid && s[i].r1 && s[i].r2) pick = i;
            if (slot < 0 && !s[i].valid) slot = i;
        end
        e_en = (pick >= 0);
        if (pick >= 0) begin
            e_op = s[pick].op; e_r1 = s[pick].v1; e_r2 = s[pick].v2;
            e_des = s[pick].des; e_imm = s[pick].imm; e_pc = s[pick].pc; e_bp = s[pick].bp;
            m[pick].valid = 0;
        end
        if (bus.disp_en_i && slot >= 0) begin
            m[slot].valid = 1;
            m[slot].op = bus.disp_op_i; m[slot].des = bus.disp_des_i;
            m[slot].imm = bus.disp_imm_i; m[slot].pc = bus.disp_pc_i; m[slot].bp = bus.disp_bp_i;
            m[slot].q1 = bus.disp_q1_i; m[slot].q2 = bus.disp_q2_i;
            m[slot].v1 = bus.disp_v1_i; m[slot].r1 = bus.disp_r1_i;
            m[slot].v2 = bus.disp_v2_i; m[slot].r2 = bus.disp_r2_i;
            if (!bus.disp_r1_i) begin
                lookup(bus.disp_q1_i, hit, d);
                if (hit) begin m[slot].r1 = 1; m[slot].v1 = d; end
            end
            if (!bus.disp_r2_i) begin
                lookup(bus.disp_q2_i, hit, d);
                if (hit) begin m[slot].r2 = 1; m[slot].v2 = d; end
            end
        end
    endtask

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m[i].valid) n++;
        return (n == 8);
    endfunction

    // Model advances on each edge, or resets immediately on reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) model_reset();
            else model_step();
        end
    end

    // Compare every output against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk_in);
            chk("br_en",   32'(bus.br_en_o),   32'(e_en));
            chk("br_op",   32'(bus.br_op_o),   32'(e_op));
            chk("br_reg1", bus.br_reg1_o,      e_r1);
            chk("br_reg2", bus.br_reg2_o,      e_r2);
            chk("br_des",  32'(bus.br_des_o),  32'(e_des));
            chk("br_imm",  bus.br_imm_o,       e_imm);
            chk("br_pc",   bus.br_pc_o,        e_pc);
            chk("br_bp",   32'(bus.br_bp_o),   32'(e_bp));
            chk("rs_full", 32'(bus.rs_full_o), 32'(model_full()));
        end
    end

    task automatic idle_in();
        bus.disp_en_i = 0; bus.disp_op_i = '0; bus.disp_v1_i = '0; bus.disp_q1_i = '0;
        bus.disp_r1_i = 0; bus.disp_v2_i = '0; bus.disp_q2_i = '0; bus.disp_r2_i = 0;
        bus.disp_des_i = '0; bus.disp_imm_i = '0; bus.disp_pc_i = '0; bus.disp_bp_i = 0;
        bus.cdb0_en_i = 0; bus.cdb0_tag_i = '0; bus.cdb0_data_i = '0;
        bus.cdb1_en_i = 0; bus.cdb1_tag_i = '0; bus.cdb1_data_i = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                        input logic r1, input logic [31:0] v2, input logic [3:0] q2,
                        input logic r2, input logic [3:0] des, input logic [31:0] imm,
                        input logic [31:0] pc, input logic bp);
        bus.disp_en_i = 1; bus.disp_op_i = op;
        bus.disp_v1_i = v1; bus.disp_q1_i = q1; bus.disp_r1_i = r1;
        bus.disp_v2_i = v2; bus.disp_q2_i = q2; bus.disp_r2_i = r2;
        bus.disp_des_i = des; bus.disp_imm_i = imm; bus.disp_pc_i = pc; bus.disp_bp_i = bp;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        idle_in();
        step();
        step();
        rst_n_in = 1'b1;
        chk("reset_br_en",   32'(bus.br_en_o),   32'd0);
        chk("reset_rs_full", 32'(bus.rs_full_o), 32'd0);
        chk("reset_reg1",    bus.br_reg1_o,      32'd0);

        // Ready BEQ: issues exactly one cycle after dispatch.
        disp(OP_BEQ, 32'd5, 4'd0, 1, 32'd5, 4'd0, 1, 4'd3, 32'd8, 32'h100, 0);
        step();
        idle_in();
        chk("beq_not_yet", 32'(bus.br_en_o), 32'd0);
        step();
        chk("beq_en",   32'(bus.br_en_o),  32'd1);
        chk("beq_reg1", bus.br_reg1_o,     32'd5);
        chk("beq_reg2", bus.br_reg2_o,     32'd5);
        chk("beq_des",  32'(bus.br_des_o), 32'd3);
        chk("beq_pc",   bus.br_pc_o,       32'h100);
        chk("beq_imm",  bus.br_imm_o,      32'd8);
        step();
        chk("beq_pulse", 32'(bus.br_en_o), 32'd0);

        // Wakeup via cdb1 two cycles after dispatch.
        disp(OP_BNE, 32'd0, 4'd7, 0, 32'd9, 4'd0, 1, 4'd4, 32'h10, 32'h200, 1);
        step();
        idle_in();
        step();
        bus.cdb1_en_i = 1; bus.cdb1_tag_i = 4'd7; bus.cdb1_data_i = 32'h2A;
        step();
        idle_in();
        chk("wake_not_chained", 32'(bus.br_en_o), 32'd0);
        step();
        chk("wake_en",   32'(bus.br_en_o), 32'd1);
        chk("wake_reg1", bus.br_reg1_o,    32'h2A);
        step();

        // Dispatch bypass from cdb0 in the dispatch cycle; cdb1 carries the
        // same tag with other data and must lose.
        disp(OP_BNE, 32'd0, 4'd7, 0, 32'd9, 4'd0, 1, 4'd5, 32'h10, 32'h204, 0);
        bus.cdb0_en_i = 1; bus.cdb0_tag_i = 4'd7; bus.cdb0_data_i = 32'h55;
        bus.cdb1_en_i = 1; bus.cdb1_tag_i = 4'd7; bus.cdb1_data_i = 32'h66;
        step();
        idle_in();
        step();
        chk("byp_en",   32'(bus.br_en_o), 32'd1);
        chk("byp_reg1", bus.br_reg1_o,    32'h55);
        step();

        // Fill all 8 slots with ops waiting on tag 1.
        for (int i = 0; i < 8; i++) begin
            disp(OP_BLT, 32'd0, 4'd1, 0, 32'(i), 4'd0, 1, 4'(i), 32'(4 * i), 32'(32'h300 + 4 * i), 0);
            step();
        end
        idle_in();
        chk("full_set",   32'(bus.rs_full_o), 32'd1);
        chk("full_no_en", 32'(bus.br_en_o),   32'd0);
        bus.cdb0_en_i = 1; bus.cdb0_tag_i = 4'd1; bus.cdb0_data_i = 32'h99;
        step();
        idle_in();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_en",   32'(bus.br_en_o),  32'd1);
            chk("drain_des",  32'(bus.br_des_o), 32'(i));
            chk("drain_reg1", bus.br_reg1_o,     32'h99);
            if (i == 0) chk("full_drop", 32'(bus.rs_full_o), 32'd0);
        end
        step();
        chk("drain_done", 32'(bus.br_en_o), 32'd0);

        // Clear with a same-cycle wakeup and dispatch.
        for (int i = 0; i < 3; i++) begin
            disp(OP_BGE, 32'd0, 4'(2 + i), 0, 32'd1, 4'd0, 1, 4'(8 + i), 32'd0, 32'h400, 0);
            step();
        end
        idle_in();
        disp(OP_JAL, 32'd1, 4'd0, 1, 32'd1, 4'd0, 1, 4'd12, 32'd4, 32'h500, 1);
        bus.cdb0_en_i = 1; bus.cdb0_tag_i = 4'd2; bus.cdb0_data_i = 32'h77;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        idle_in();
        chk("clr_en",   32'(bus.br_en_o),   32'd0);
        chk("clr_full", 32'(bus.rs_full_o), 32'd0);
        bus.cdb0_en_i = 1; bus.cdb0_tag_i = 4'd3; bus.cdb0_data_i = 32'h1;
        bus.cdb1_en_i = 1; bus.cdb1_tag_i = 4'd4; bus.cdb1_data_i = 32'h2;
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr_no_issue", 32'(bus.br_en_o), 32'd0);
        end

        // rdy_in freeze with a ready entry present.
        disp(OP_JALR, 32'h1000, 4'd0, 1, 32'd0, 4'd0, 1, 4'd6, 32'h20, 32'h600, 0);
        step();
        idle_in();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_en", 32'(bus.br_en_o), 32'd0);
        end
        rdy_in = 1'b1;
        step();
        chk("frz_issue", 32'(bus.br_en_o),  32'd1);
        chk("frz_reg1",  bus.br_reg1_o,     32'h1000);
        chk("frz_des",   32'(bus.br_des_o), 32'd6);
        step();
        chk("frz_once", 32'(bus.br_en_o), 32'd0);

        // Async reset between edges while an issue pulse is high.
        disp(OP_BGEU, 32'hA, 4'd0, 1, 32'hB, 4'd0, 1, 4'd9, 32'hC, 32'h700, 1);
        step();
        idle_in();
        disp(OP_BLTU, 32'hD, 4'd0, 1, 32'hE, 4'd0, 1, 4'd10, 32'hF, 32'h704, 0);
        step();
        idle_in();
        chk("pre_rst_en", 32'(bus.br_en_o), 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_en",   32'(bus.br_en_o),   32'd0);
        chk("arst_reg1", bus.br_reg1_o,      32'd0);
        chk("arst_pc",   bus.br_pc_o,        32'd0);
        chk("arst_bp",   32'(bus.br_bp_o),   32'd0);
        chk("arst_full", 32'(bus.rs_full_o), 32'd0);
        step();
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_none", 32'(bus.br_en_o), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- Reservation station and issue scheduler for the combinational branch unit.
- Holds dispatched JAL/JALR/Bxx ops, snoops two CDBs for operand wakeup, and picks one ready entry per cycle.
- Drives the branch unit's inputs from an issue register.
- A flush from the ROB empties it.

Parameters:
- RS_SIZE, 8, number of entries (power of two)
- IDX_W, 3, log2(RS_SIZE)
- TAG_W, 4, ROB tag width
- DATA_W, 32, operand, immediate and PC width
- OP_W, 6, internal opcode width

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; 0 freezes the block
- clear_i  in  1  misprediction flush from ROB
- disp_en_i  in  1  dispatch valid
- disp_op_i  in  OP_W  opcode
- disp_v1_i  in  DATA_W  rs1 value
- disp_q1_i  in  TAG_W  rs1 producer tag
- disp_r1_i  in  1  rs1 value valid
- disp_v2_i  in  DATA_W  rs2 value
- disp_q2_i  in  TAG_W  rs2 producer tag
- disp_r2_i  in  1  rs2 value valid
- disp_des_i  in  TAG_W  destination ROB tag
- disp_imm_i  in  DATA_W  immediate
- disp_pc_i  in  DATA_W  instruction PC
- disp_bp_i  in  1  predicted-taken flag
- cdb0_en_i, cdb1_en_i  in  1  broadcast valid
- cdb0_tag_i, cdb1_tag_i  in  TAG_W  broadcast tag
- cdb0_data_i, cdb1_data_i  in  DATA_W  broadcast value
- rs_full_o  out  1  no free entry
- br_en_o  out  1  issue valid to branch unit
- br_op_o  out  OP_W  issued opcode
- br_reg1_o, br_reg2_o  out  DATA_W  issued operands
- br_des_o  out  TAG_W  issued destination tag
- br_imm_o, br_pc_o  out  DATA_W  issued immediate / PC
- br_bp_o  out  1  issued prediction

Behaviour:
- Reset (async, rst_n_in=0):
  - All entry valid bits are 0.
  - All br_* outputs are 0; br_en_o=0.
  - rs_full_o=0.
- Entry fields: valid, op, v1/q1/r1, v2/q2/r2, des, imm, pc, bp.
- Priority per rising edge: reset > clear_i > !rdy_in > normal.
- clear_i=1:
  - All valid bits are cleared.
  - br_en_o=0 next cycle.
  - A same-cycle dispatch is dropped.
  - Applies regardless of rdy_in.
- rdy_in=0:
  - Entries and issue-register fields hold.
  - br_en_o is cleared to 0, so a pulse is never repeated.
  - Dispatch and CDB are ignored; the upstream stalls under the same rdy_in.
- Dispatch:
  - Accepted when disp_en_i=1, writing the lowest-index free entry.
  - Dispatch while rs_full_o=1 is illegal and is assertion-checked; the entry is not written.
- Dispatch bypass: if r1=0 and q1 matches an enabled CDB tag this cycle, the entry is stored with r1=1 and v1 taken from that CDB. Same rule for operand 2.
- Wakeup:
  - Every valid entry with rX=0 compares qX against both CDBs.
  - On a match it captures the data and sets rX=1 at the edge.
  - If both CDBs carry the same tag, cdb0 wins.
- Ready: valid & r1 & r2. JAL is dispatched with r1=r2=1.
- Issue:
  - Each cycle, the lowest-index ready entry (combinational priority select) is latched into br_* with br_en_o=1 at the edge.
  - That entry's valid is cleared at the same edge.
  - br_en_o is a one-cycle pulse. If no entry is ready, br_en_o=0 and the other br_* fields hold.
- Latency:
  - An entry dispatched ready at edge N issues at edge N+1 (br_en_o high in cycle N+1..N+2).
  - An entry woken at edge M issues at edge M+1 at the earliest.
  - Wakeup and select are never chained combinationally.
- Slot reuse: rs_full_o is driven from registered valid bits only. A slot freed by issue at edge N becomes allocatable from cycle N onward.
- Back-to-back issue: one per cycle, sustained.
- Tags are compared on full TAG_W. No tag value is reserved; readiness is carried only by the rX bits.

Decomposition:
- Shared defines header:
  - widths: OpBus, TagBus, DataBus, AddrBus
  - JAL/JALR/BEQ..BGEU opcode encodings
  - Enable/Disable, Suc/Fail, Null
- Sub-module branch_rs_sel:
  - Parameterised lowest-index priority encoder.
  - Input RS_SIZE bit vector; outputs found flag and index.
  - Instantiated twice: free-slot pick and ready pick.

Test Plan:
- Ready BEQ: reset, dispatch BEQ (v1=5, v2=5, des=3, pc=0x100, imm=8, both ready) at edge 0 -> br_en_o=1 in cycle 1 only, with br_reg1_o=5, br_reg2_o=5, br_des_o=3, br_pc_o=0x100, br_imm_o=8. rs_full_o stays 0.
- Wakeup and bypass:
  - Dispatch BNE with q1=7 pending; cdb1 tag 7, data 0x2A two cycles later -> issue the following edge with br_reg1_o=0x2A.
  - Repeat with cdb0 tag 7 in the dispatch cycle itself -> entry stored ready and issued next edge.
- Full: dispatch 8 ops with q1=1 pending -> rs_full_o=1 after the 8th edge and no br_en_o. Broadcast tag 1 on cdb0 -> all 8 wake; entries 0..7 issue on 8 consecutive cycles in index order; rs_full_o drops after the first issue.
- Clear: 3 pending entries, one becomes ready the same cycle clear_i=1 with a dispatch -> next cycle all empty, br_en_o=0, dispatch dropped. No issue afterwards even when its tag broadcasts.
- rdy_in freeze: ready entry present, rdy_in=0 for 3 cycles -> br_en_o=0 throughout and entries held. rdy_in=1 -> issues once.
- Async reset mid-issue: rst_n_in low between edges while br_en_o=1 -> br_en_o and all outputs go 0 immediately, before the next edge. After release, no stale issue occurs.
